// File: rtl/pmu_ctrl.sv
// pmu_ctrl: packs serial bit pairs into 5-pair blocks, issues them to the PMU under survivor-slot
// credits, and drains/refreshes the pipeline at frame boundaries. Define PMU_CTRL_STATS_EN for stall_cycles.
//
// state     | meaning
// S_REFRESH | pulse refresh once, metrics re-initialised
// S_COLLECT | accept pairs, issue a block when 5 are held and a credit is free
// S_DRAIN   | frame complete, wait for every in-flight block to leave the PMU
module pmu_ctrl #(
   parameter int unsigned FRAME_BLOCKS = 4,
   parameter int unsigned SLOTS        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pair_in,
   input  logic        pair_valid,
   output logic        pair_ready,
   output logic [1:0]  bit_pair_3,
   output logic [1:0]  bit_pair_4,
   output logic [1:0]  bit_pair_5,
   output logic [1:0]  bit_pair_6,
   output logic [1:0]  bit_pair_7,
   output logic        blk_valid,
   output logic [2:0]  write_pointer,
   output logic        refresh,
   input  logic        pmu_valid_out,
   input  logic        tb_free,
   output logic        frame_done,
   output logic [2:0]  inflight,
   output logic        err
`ifdef PMU_CTRL_STATS_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   localparam int unsigned CW       = $clog2(SLOTS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(SLOTS);
   localparam logic [7:0]    LAST_BLK = 8'(FRAME_BLOCKS - 1);

   typedef enum logic [1:0] {
      S_REFRESH = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [4:0][1:0] pairs_q, pairs_d;
   logic [CW-1:0]   credits_q, credits_d;
   logic [7:0]      blk_cnt_q, blk_cnt_d;
   logic [2:0]      inflight_q, inflight_d;
   logic [2:0]      wp_q, wp_d;
   logic            err_q, err_d;
   logic            pair_ready_q, pair_ready_d;
   logic            blk_valid_q, blk_valid_d;
   logic            refresh_q, refresh_d;
   logic            frame_done_q, frame_done_d;

   logic accept;
   logic issue;
   logic last_blk;
   logic free_ok;
   logic done_ok;
   logic drained;

   always_comb begin
      accept   = pair_valid && pair_ready_q;
      issue    = (state_q == S_COLLECT) && (cnt_q == 3'd5) && (credits_q != '0);
      last_blk = issue && (blk_cnt_q == LAST_BLK);
      free_ok  = tb_free && (credits_q != CRED_MAX);
      done_ok  = pmu_valid_out && (inflight_q != 3'd0);
   end

   // Datapath next-state
   always_comb begin
      pairs_d = pairs_q;
      for (int i = 0; i < 5; i++) begin
         if (accept && (cnt_q == 3'(i))) begin
            pairs_d[i] = pair_in;
         end
      end

      cnt_d = cnt_q;
      if (issue) begin
         cnt_d = 3'd0;
      end else if (accept) begin
         cnt_d = cnt_q + 3'd1;
      end

      inflight_d = inflight_q;
      case ({blk_valid_q, done_ok})
         2'b10:   inflight_d = inflight_q + 3'd1;
         2'b01:   inflight_d = inflight_q - 3'd1;
         default: inflight_d = inflight_q;
      endcase
      drained = (inflight_d == 3'd0);

      credits_d = credits_q;
      case ({issue, free_ok})
         2'b10:   credits_d = credits_q - CW'(1);
         2'b01:   credits_d = credits_q + CW'(1);
         default: credits_d = credits_q;
      endcase

      blk_cnt_d = blk_cnt_q;
      if ((state_q == S_DRAIN) && drained) begin
         blk_cnt_d = 8'd0;
      end else if (issue) begin
         blk_cnt_d = blk_cnt_q + 8'd1;
      end

      wp_d  = wp_q + 3'(blk_valid_q);
      err_d = err_q | (tb_free && !free_ok) | (pmu_valid_out && !done_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REFRESH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_REFRESH: if (refresh_q) state_d = S_COLLECT;
         S_COLLECT: if (last_blk)  state_d = S_DRAIN;
         S_DRAIN:   if (drained)   state_d = S_REFRESH;
         default:                  state_d = S_REFRESH;
      endcase
   end

   // Outputs are registered, so each is decoded one cycle ahead from the next state
   always_comb begin
      refresh_d    = (state_q == S_REFRESH) && !refresh_q;
      frame_done_d = (state_q == S_DRAIN) && drained;
      pair_ready_d = (state_d == S_COLLECT) && (cnt_d != 3'd5);
      blk_valid_d  = issue;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= 3'd0;
         pairs_q      <= '0;
         credits_q    <= CRED_MAX;
         blk_cnt_q    <= 8'd0;
         inflight_q   <= 3'd0;
         wp_q         <= 3'd0;
         err_q        <= 1'b0;
         pair_ready_q <= 1'b0;
         blk_valid_q  <= 1'b0;
         refresh_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         pairs_q      <= pairs_d;
         credits_q    <= credits_d;
         blk_cnt_q    <= blk_cnt_d;
         inflight_q   <= inflight_d;
         wp_q         <= wp_d;
         err_q        <= err_d;
         pair_ready_q <= pair_ready_d;
         blk_valid_q  <= blk_valid_d;
         refresh_q    <= refresh_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef PMU_CTRL_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_COLLECT) && (cnt_q == 3'd5) && (credits_q == '0) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 16'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

   assign pair_ready    = pair_ready_q;
   assign bit_pair_3    = pairs_q[0];
   assign bit_pair_4    = pairs_q[1];
   assign bit_pair_5    = pairs_q[2];
   assign bit_pair_6    = pairs_q[3];
   assign bit_pair_7    = pairs_q[4];
   assign blk_valid     = blk_valid_q;
   assign write_pointer = wp_q;
   assign refresh       = refresh_q;
   assign frame_done    = frame_done_q;
   assign inflight      = inflight_q;
   assign err           = err_q;

endmodule

// File: tb/tb_pmu_ctrl.sv
// Scoreboard bench for pmu_ctrl: driver pushes expected blocks, negedge monitor checks issues,
// frame sequencing, inflight/credit/err bookkeeping against an event-count model.
module tb_pmu_ctrl;
   localparam int FB    = 4;
   localparam int SLOTS = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] pair_in = 2'd0;
   logic       pair_valid = 1'b0;
   logic       pair_ready;
   logic [1:0] bit_pair_3, bit_pair_4, bit_pair_5, bit_pair_6, bit_pair_7;
   logic       blk_valid;
   logic [2:0] write_pointer;
   logic       refresh;
   logic       pmu_valid_out;
   logic       tb_free;
   logic       frame_done;
   logic [2:0] inflight;
   logic       err;
`ifdef PMU_CTRL_STATS_EN
   logic [15:0] stall_cycles;
`endif

   pmu_ctrl #(.FRAME_BLOCKS(FB), .SLOTS(SLOTS)) dut (
      .clk(clk), .rst(rst), .pair_in(pair_in), .pair_valid(pair_valid), .pair_ready(pair_ready),
      .bit_pair_3(bit_pair_3), .bit_pair_4(bit_pair_4), .bit_pair_5(bit_pair_5),
      .bit_pair_6(bit_pair_6), .bit_pair_7(bit_pair_7), .blk_valid(blk_valid),
      .write_pointer(write_pointer), .refresh(refresh), .pmu_valid_out(pmu_valid_out),
      .tb_free(tb_free), .frame_done(frame_done), .inflight(inflight), .err(err)
`ifdef PMU_CTRL_STATS_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // PMU model: each issued block returns valid_out five cycles later
   logic [4:0] pmu_pipe = 5'd0;
   logic pmu_en = 1'b1, auto_free = 1'b0, pmu_force = 1'b0, free_force = 1'b0;
   always @(posedge clk) begin
      if (rst) pmu_pipe <= 5'd0;
      else     pmu_pipe <= {pmu_pipe[3:0], blk_valid & pmu_en};
   end
   assign pmu_valid_out = pmu_pipe[4] | pmu_force;
   assign tb_free       = (pmu_pipe[4] & auto_free) | free_force;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [9:0] pairs;
      logic [2:0] wp;
   } blk_t;
   blk_t       exp_q[$];
   logic [1:0] cur[$];
   int         blocks_model = 0;

   task automatic push_pair(input logic [1:0] p);
      blk_t b;
      cur.push_back(p);
      if (cur.size() == 5) begin
         b.pairs = {cur[4], cur[3], cur[2], cur[1], cur[0]};
         b.wp    = 3'(blocks_model % 8);
         blocks_model++;
         exp_q.push_back(b);
         cur.delete();
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_pair(input logic [1:0] p, input bit gaps);
      bit ok = 1'b0;
      int t  = 0;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
         pair_valid = 1'b0;
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
      end
      pair_in    = p;
      pair_valid = 1'b1;
      while (!ok && t < 300) begin
         @(negedge clk);
         if (pair_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
         t++;
      end
      pair_valid = 1'b0;
      check("pair_accept", 64'(ok), 64'(1));
      if (ok) push_pair(p);
   endtask

   task automatic send_block(input logic [9:0] pv, input bit gaps, input bit lat);
      for (int i = 0; i < 5; i++) send_pair(pv[2*i +: 2], gaps);
      if (lat) begin
         @(negedge clk);
         check("issue_wait", 64'({blk_valid, pair_ready}), 64'(2'b00));
         @(negedge clk);
         check("issue_cycle", 64'({blk_valid, pair_ready}), 64'({1'b1, (blocks_model % FB) != 0}));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      pair_valid = 1'b0;
      pmu_force  = 1'b0;
      free_force = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'({pair_ready, bit_pair_3, bit_pair_4, bit_pair_5, bit_pair_6, bit_pair_7,
                                  blk_valid, write_pointer, refresh, frame_done, inflight, err}), 64'(0));
      cur.delete();
      exp_q.delete();
      blocks_model = 0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Eight issues with no frees, then the ninth block must wait for a credit
   task automatic stall_test(input int k);
      for (int b = 0; b < 8; b++) send_block(10'($urandom), 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) send_pair(2'($urandom), 1'b1);
      repeat (k) begin
         @(negedge clk);
         check("stall_hold", 64'({pair_ready, blk_valid}), 64'(2'b00));
      end
      @(posedge clk);
      #1 free_force = 1'b1;
      @(posedge clk);
      #1 free_force = 1'b0;
      @(negedge clk);
      check("stall_release_wait", 64'(blk_valid), 64'(0));
      @(negedge clk);
      check("stall_release_issue", 64'(blk_valid), 64'(1));
`ifdef PMU_CTRL_STATS_EN
      check("stall_cycles", 64'(stall_cycles), 64'(k + 1));
`endif
      @(posedge clk);
      #1;
   endtask

   // Monitor / reference bookkeeping
   int   infl_m, cred_m, issued_m;
   bit   err_m, frame_pend, prev_fd;
   blk_t mon_e;
   always @(negedge clk) begin
      if (rst) begin
         infl_m = 0; cred_m = SLOTS; issued_m = 0;
         err_m = 1'b0; frame_pend = 1'b0; prev_fd = 1'b0;
      end else begin
         check("inflight", 64'(inflight), 64'(infl_m));
         check("err", 64'(err), 64'(err_m));
         if (prev_fd) check("refresh_after_frame_done", 64'(refresh), 64'(1));
         if (refresh) check("ready_in_refresh", 64'(pair_ready), 64'(0));
         if (blk_valid) begin
            check("blk_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("blk_pairs", 64'({bit_pair_7, bit_pair_6, bit_pair_5, bit_pair_4, bit_pair_3}),
                     64'(mon_e.pairs));
               check("write_pointer", 64'(write_pointer), 64'(mon_e.wp));
            end
            issued_m++;
            cred_m--;
            if (issued_m % FB == 0) frame_pend = 1'b1;
         end
         if (frame_pend && !frame_done) check("ready_in_drain", 64'(pair_ready), 64'(0));
         if (frame_done) begin
            check("frame_done_legal", 64'({frame_pend, inflight}), 64'({1'b1, 3'd0}));
            frame_pend = 1'b0;
         end
         prev_fd = frame_done;
         if (tb_free) begin
            if (cred_m == SLOTS) err_m = 1'b1;
            else                 cred_m++;
         end
         if (pmu_valid_out) begin
            if (infl_m == 0) err_m = 1'b1;
            else             infl_m--;
         end
         if (blk_valid) infl_m++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, refresh timing, first block 0,1,2,3,0
      do_reset();
      @(negedge clk);
      check("refresh_cycle0", 64'({refresh, pair_ready}), 64'(2'b00));
      @(negedge clk);
      check("refresh_cycle1", 64'({refresh, pair_ready}), 64'(2'b10));
      @(negedge clk);
      check("ready_cycle2", 64'({refresh, pair_ready}), 64'(2'b01));
      @(posedge clk);
      #1;
      send_block({2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 1'b1);

      // Nine streamed blocks with frees, across frame boundaries
      do_reset();
      auto_free = 1'b1;
      for (int b = 0; b < 9; b++) send_block(10'($urandom), 1'b1, 1'b1);
      repeat (20) @(posedge clk);
      #1 auto_free = 1'b0;

      // Credit exhaustion and release
      do_reset();
      stall_test($urandom_range(2, 6));
      repeat (20) @(posedge clk);
      #1;

      // Protocol errors: stray valid_out and surplus free are ignored, err sticks
      do_reset();
      repeat (4) @(posedge clk);
      #1 pmu_force = 1'b1;
      @(posedge clk);
      #1 pmu_force = 1'b0;
      @(negedge clk);
      check("err_stray_valid", 64'({err, inflight}), 64'({1'b1, 3'd0}));
      @(posedge clk);
      #1 free_force = 1'b1;
      @(posedge clk);
      #1 free_force = 1'b0;
      repeat (5) @(negedge clk);
      check("err_sticky", 64'(err), 64'(1));
      @(posedge clk);
      #1;
      stall_test(3);
      repeat (20) @(posedge clk);
      #1;

      // Reset with a partial block pending
      do_reset();
      for (int i = 0; i < 3; i++) send_pair(2'($urandom), 1'b0);
      do_reset();
      send_block(10'($urandom), 1'b0, 1'b1);
      send_block(10'($urandom), 1'b1, 1'b1);
      repeat (20) @(posedge clk);

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
